// File: rtl/credit_pkg.sv
// Shared constants, helper function and payload type for the credit-based link blocks.
package credit_pkg;

   localparam int CREDIT_WIDTH_DEFAULT = 64;
   localparam int CREDIT_DEPTH_DEFAULT = 4;

   typedef logic [CREDIT_WIDTH_DEFAULT-1:0] flit_t;

   // Counters must hold the full range 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/credit_return_ctr.sv
// Pending-credit counter and registered credit-return pulse; shared with the credit sender side.
module credit_return_ctr
   import credit_pkg::*;
#(
   parameter int  DEPTH = CREDIT_DEPTH_DEFAULT,
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pop,
   output logic cred_ret
);

   logic [CNT_W-1:0] pending;
   logic [CNT_W-1:0] pending_next;
   logic             cred_next;

   // Reset loads DEPTH owed credits, which become the init pulse train.
   always_comb begin
      cred_next    = (pending != '0);
      pending_next = pending - CNT_W'(cred_next) + CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= CNT_W'(DEPTH);
         cred_ret <= 1'b0;
      end else begin
         pending  <= pending_next;
         cred_ret <= cred_next;
      end
   end

endmodule

// File: rtl/credit_rx_fifo.sv
// Credit-based link receiver: DEPTH-entry FIFO plus credit return.
// Optional CREDIT_RX_OVF_CHECK_EN adds a sticky ovf_err output.
module credit_rx_fifo
   import credit_pkg::*;
#(
   parameter int  WIDTH = CREDIT_WIDTH_DEFAULT,
   parameter int  DEPTH = CREDIT_DEPTH_DEFAULT,
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             cred_ret,
   output logic [CNT_W-1:0] count
`ifdef CREDIT_RX_OVF_CHECK_EN
   ,
   output logic             ovf_err
`endif
);

   localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             wr_en;
   logic             ovf;
   logic             pop;

   function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Link side has no ready: a write into a full FIFO is dropped, judged on
   // registered count. Consumer side: head transfers when out_valid && out_ready.
   assign full      = (count == FULL);
   assign wr_en     = in_valid && !full;
   assign ovf       = in_valid && full;
   assign out_valid = rst_n && (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= adv(wr_ptr);
         if (pop)   rd_ptr <= adv(rd_ptr);
         count <= count + CNT_W'(wr_en) - CNT_W'(pop);
      end
   end

   credit_return_ctr #(.DEPTH(DEPTH)) u_cred (
      .clk      (clk),
      .rst_n    (rst_n),
      .pop      (pop),
      .cred_ret (cred_ret)
   );

`ifdef CREDIT_RX_OVF_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
      end else if (ovf) begin
         ovf_err <= 1'b1;
         $error("credit_rx_fifo overflow: dropped flit %h", in_data);
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

endmodule
